// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_pkg
// Description : Shared types and constants for the S-box scheduler slice.
//               Owner encoding, the {valid, owner} tag carried alongside each
//               operand through the shared S-box pipeline, and byte/share
//               width constants.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_sbox_pkg;

    localparam int BYTE_W    = 8;
    localparam int D_DEFAULT = 2;

    // Which requester an in-flight S-box operation belongs to
    localparam logic OWNER_KS = 1'b0;
    localparam logic OWNER_DP = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } sbox_tag_t;

    localparam sbox_tag_t TAG_EMPTY = '{valid: 1'b0, owner: OWNER_KS};

    // Bus width for a byte carried as d shares
    function automatic int share_bus_w(input int d);
        return BYTE_W * d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sbox_scheduler_if
// Description : Bundles every non-clock signal of the S-box scheduler.
//               master : the environment (key schedule, datapath, round
//                        controller and the shared S-box unit)
//               slave  : the scheduler itself
// Signals     : ks_/dp_ valid, ready, data, inv   request handshakes
//               ks_/dp_ rvalid, rdata              result returns
//               sbox_in, sbox_inv, sbox_out         shared S-box unit link
//               drain, idle                        drain-to-idle control
// Revision    : 1.0 - initial release
// ============================================================================
interface sbox_scheduler_if
    import aes_sbox_pkg::*;
#(
    parameter int D = D_DEFAULT
) ();

    localparam int W = share_bus_w(D);

    // Key-schedule requester
    logic         ks_valid;
    logic         ks_ready;
    logic [W-1:0] ks_data;
    logic         ks_inv;
    logic         ks_rvalid;
    logic [W-1:0] ks_rdata;

    // State datapath requester
    logic         dp_valid;
    logic         dp_ready;
    logic [W-1:0] dp_data;
    logic         dp_inv;
    logic         dp_rvalid;
    logic [W-1:0] dp_rdata;

    // Shared S-box unit
    logic [W-1:0] sbox_in;
    logic         sbox_inv;
    logic [W-1:0] sbox_out;

    // Drain control
    logic         drain;
    logic         idle;

    modport master (
        output ks_valid, ks_data, ks_inv,
        output dp_valid, dp_data, dp_inv,
        output sbox_out, drain,
        input  ks_ready, ks_rvalid, ks_rdata,
        input  dp_ready, dp_rvalid, dp_rdata,
        input  sbox_in, sbox_inv, idle
    );

    modport slave (
        input  ks_valid, ks_data, ks_inv,
        input  dp_valid, dp_data, dp_inv,
        input  sbox_out, drain,
        output ks_ready, ks_rvalid, ks_rdata,
        output dp_ready, dp_rvalid, dp_rdata,
        output sbox_in, sbox_inv, idle
    );

endinterface
`default_nettype wire

// File: rtl/sbox_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sbox_tag_pipe
// Description : LATENCY-deep shift register of {valid, owner} tags that runs
//               in lock-step with the shared S-box pipeline. Shifts every
//               cycle; synchronous clear empties every stage.
// Ports       : clk      clock, rising edge
//               rst      synchronous clear, active-high
//               tail_tag tag entering stage 0 this cycle
//               head_tag tag leaving the last stage (aligned with sbox_out)
//               busy     at least one stage holds a valid tag
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_tag_pipe
    import aes_sbox_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire sbox_tag_t tail_tag,
    output sbox_tag_t      head_tag,
    output logic           busy
);

    sbox_tag_t            r_stage [LATENCY];
    logic [LATENCY-1:0]   w_stage_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= TAG_EMPTY;
            end
        end else begin
            r_stage[0] <= tail_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    generate
        for (genvar g = 0; g < LATENCY; g++) begin : g_stage_valid
            assign w_stage_valid[g] = r_stage[g].valid;
        end
    endgenerate

    assign head_tag = r_stage[LATENCY-1];
    assign busy     = |w_stage_valid;

endmodule
`default_nettype wire

// File: rtl/sbox_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sbox_scheduler
// Description : Time-shares one pipelined (masked) S-box unit between the
//               key schedule (ks) and the state datapath (dp). Round-robin
//               arbitration, at most one grant per cycle; each grant is
//               tagged with its owner and the result is routed back to that
//               owner exactly LATENCY cycles later. drain blocks new grants
//               so the unit can empty before a key change.
// Ports       : clk  clock, rising edge
//               rst  synchronous reset, active-high
//               bus  sbox_scheduler_if.slave (handshakes, results, S-box
//                    unit link, drain/idle)
// Parameters  : D        shares per byte
//               LATENCY  register stages inside the S-box unit (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_scheduler
    import aes_sbox_pkg::*;
#(
    parameter int D       = D_DEFAULT,
    parameter int LATENCY = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sbox_scheduler_if.slave bus
);

    localparam int W = share_bus_w(D);

    logic      r_last_owner;   // owner of the most recent transfer
    logic      w_ks_grant;
    logic      w_dp_grant;
    logic      w_xfer;
    sbox_tag_t w_tail_tag;
    sbox_tag_t w_head_tag;
    logic      w_busy;

    // ------------------------------------------------------------------
    // Arbitration. A grant is the ready itself, so ready is only raised
    // for a requester that is actually presenting a request. On a tie the
    // requester that did not win last time is served.
    // ------------------------------------------------------------------
    always_comb begin
        w_ks_grant = 1'b0;
        w_dp_grant = 1'b0;
        if (!rst && !bus.drain) begin
            if (bus.ks_valid && (!bus.dp_valid || (r_last_owner == OWNER_DP))) begin
                w_ks_grant = 1'b1;
            end else if (bus.dp_valid) begin
                w_dp_grant = 1'b1;
            end
        end
    end

    assign w_xfer       = w_ks_grant | w_dp_grant;
    assign bus.ks_ready = w_ks_grant;
    assign bus.dp_ready = w_dp_grant;

    // Pointer resets to "dp last" so ks wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWNER_DP;
        end else if (w_xfer) begin
            r_last_owner <= w_dp_grant ? OWNER_DP : OWNER_KS;
        end
    end

    // ------------------------------------------------------------------
    // Operand mux. Shares of a requester that is not granted are never
    // forwarded: the S-box sees all-zero when nothing is granted.
    // ------------------------------------------------------------------
    always_comb begin
        bus.sbox_in  = '0;
        bus.sbox_inv = 1'b0;
        if (w_ks_grant) begin
            bus.sbox_in  = bus.ks_data;
            bus.sbox_inv = bus.ks_inv;
        end else if (w_dp_grant) begin
            bus.sbox_in  = bus.dp_data;
            bus.sbox_inv = bus.dp_inv;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline, aligned with the S-box unit: the tag captured at the
    // transfer edge reaches the head in the same cycle the unit presents
    // the matching result on sbox_out.
    // ------------------------------------------------------------------
    always_comb begin
        w_tail_tag.valid = w_xfer;
        w_tail_tag.owner = w_dp_grant ? OWNER_DP : OWNER_KS;
    end

    sbox_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tail_tag (w_tail_tag),
        .head_tag (w_head_tag),
        .busy     (w_busy)
    );

    // ------------------------------------------------------------------
    // Result routing. Result buses are zero outside their rvalid pulse so
    // one owner never observes the other owner's shares.
    // ------------------------------------------------------------------
    assign bus.ks_rvalid = w_head_tag.valid && (w_head_tag.owner == OWNER_KS);
    assign bus.dp_rvalid = w_head_tag.valid && (w_head_tag.owner == OWNER_DP);
    assign bus.ks_rdata  = bus.ks_rvalid ? bus.sbox_out : {W{1'b0}};
    assign bus.dp_rdata  = bus.dp_rvalid ? bus.sbox_out : {W{1'b0}};

    assign bus.idle = !w_busy && !w_xfer;

endmodule
`default_nettype wire
